// File: rtl/rf_write_scheduler_pkg.sv
// Shared widths, register-file constants and FSM encoding for the
// register-file write scheduler.
package rf_write_scheduler_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO  = '0;
  localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(NREG - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Requester handshakes, init control and register-file write bus of the
// write scheduler; master is the requester side, slave is the scheduler.
interface rf_write_scheduler_if;
  import rf_write_scheduler_pkg::*;

  logic              init_start;
  logic              init_busy;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output init_start,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  init_busy, req0_ready, req1_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  init_start,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output init_busy, req0_ready, req1_ready,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; rr_last holds the index of the most recent
// grant, and req0 wins a tie when rr_last is 1.
module rf_rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic enable,
  output logic gnt0,
  output logic gnt1
);

  logic rr_last_q;
  logic rr_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  // Uncontended grants also move rr_last so fairness tracks actual usage.
  always_comb begin
    gnt0      = enable && valid0 && (!valid1 || rr_last_q);
    gnt1      = enable && valid1 && (!valid0 || !rr_last_q);
    rr_last_d = rr_last_q;
    if (gnt0) begin
      rr_last_d = 1'b0;
    end else if (gnt1) begin
      rr_last_d = 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Owns the register-file write port: clears r1..r31 after reset or on
// request, then shares the port between two requesters round-robin.
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rf_write_scheduler_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic arb_en;
  logic gnt0;
  logic gnt1;

  assign arb_en = (state_q == RUN) && !bus.init_start;

  rf_rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .enable (arb_en),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= CLR_FIRST;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Writes to r0 are consumed but never reach the register file.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (state_q)
      CLEAR: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = clr_ptr_q;
        rf_wdata_d = '0;
        if (clr_ptr_q == CLR_LAST) begin
          state_d   = RUN;
          clr_ptr_d = CLR_FIRST;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      RUN: begin
        if (bus.init_start) begin
          state_d   = CLEAR;
          clr_ptr_d = CLR_FIRST;
        end else if (gnt0) begin
          rf_we_d    = (bus.req0_addr != REG_ZERO);
          rf_waddr_d = bus.req0_addr;
          rf_wdata_d = bus.req0_data;
        end else if (gnt1) begin
          rf_we_d    = (bus.req1_addr != REG_ZERO);
          rf_waddr_d = bus.req1_addr;
          rf_wdata_d = bus.req1_data;
        end
      end
    endcase
  end

  always_comb begin
    bus.init_busy  = (state_q == CLEAR);
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.rf_we      = rf_we_q;
    bus.rf_waddr   = rf_waddr_q;
    bus.rf_wdata   = rf_wdata_q;
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: expected register-file writes are
// queued when a grant is expected and popped when rf_we is seen.
module tb_rf_write_scheduler;
  import rf_write_scheduler_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  wr_t  sb_q[$];

  rf_write_scheduler_if bus();

  rf_write_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                                input logic init);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    bus.init_start = init;
  endtask

  task automatic pop_and_check(input string tag);
    wr_t exp_wr;
    n_vec++;
    assert (sb_q.size() != 0)
    else begin
      n_miss++;
      $error("[TB] FAIL %s.unexpected_write observed=addr %0d data %h expected=no write", tag, bus.rf_waddr, bus.rf_wdata);
    end
    if (sb_q.size() != 0) begin
      exp_wr = sb_q.pop_front();
      check_output({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(exp_wr.addr));
      check_output({tag, ".wdata"}, bus.rf_wdata, exp_wr.data);
    end
  endtask

  // One RUN cycle: drive after the edge, sample at the following negedge.
  task automatic step(input string tag,
                      input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      input logic init, input logic exp_r0, input logic exp_r1, input logic exp_we);
    @(posedge clk);
    #1;
    apply_stimulus(v0, a0, d0, v1, a1, d1, init);
    @(negedge clk);
    check_output({tag, ".req0_ready"}, 32'(bus.req0_ready), 32'(exp_r0));
    check_output({tag, ".req1_ready"}, 32'(bus.req1_ready), 32'(exp_r1));
    check_output({tag, ".rf_we"}, 32'(bus.rf_we), 32'(exp_we));
    if (bus.rf_we === 1'b1) pop_and_check(tag);
    if (exp_r0 && a0 != REG_ZERO) sb_q.push_back('{addr: a0, data: d0});
    if (exp_r1 && a1 != REG_ZERO) sb_q.push_back('{addr: a1, data: d1});
  endtask

  // Called at the negedge just before the first clear write becomes visible.
  task automatic run_clear(input string tag, input logic pulse_init, input logic exp_r0_last,
                           input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      check_output($sformatf("%s.clr%0d.we", tag, k), 32'(bus.rf_we), 32'd1);
      check_output($sformatf("%s.clr%0d.waddr", tag, k), 32'(bus.rf_waddr), 32'(k));
      check_output($sformatf("%s.clr%0d.wdata", tag, k), bus.rf_wdata, 32'd0);
      check_output($sformatf("%s.clr%0d.busy", tag, k), 32'(bus.init_busy), 32'(k < 31));
      check_output($sformatf("%s.clr%0d.r0", tag, k), 32'(bus.req0_ready), 32'((k == 31) ? exp_r0_last : 1'b0));
      check_output($sformatf("%s.clr%0d.r1", tag, k), 32'(bus.req1_ready), 32'd0);
      if (pulse_init && k == 10) bus.init_start = 1'b1;
      if (pulse_init && k == 11) bus.init_start = 1'b0;
    end
    if (exp_r0_last) sb_q.push_back('{addr: a0, data: d0});
  endtask

  initial begin
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_output("rst.we", 32'(bus.rf_we), 32'd0);
    check_output("rst.waddr", 32'(bus.rf_waddr), 32'd0);
    check_output("rst.wdata", bus.rf_wdata, 32'd0);
    check_output("rst.busy", 32'(bus.init_busy), 32'd1);
    check_output("rst.r0", 32'(bus.req0_ready), 32'd0);
    check_output("rst.r1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear("boot", 1'b1, 1'b0, 5'd0, 32'd0);

    step("idle0", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("r0a5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("r0a5.wr", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("r0a5.off", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("hold.waddr", 32'(bus.rf_waddr), 32'd5);
    check_output("hold.wdata", bus.rf_wdata, 32'hDEADBEEF);

    step("r1a0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    step("r1a0.drop", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    step("rr1", 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rr2", 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    step("rr3", 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b1, 1'b0, 1'b1);
    step("rr4", 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    step("rr5", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("rr6", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    step("same1", 1'b1, 5'd10, 32'hA, 1'b1, 5'd10, 32'hB, 1'b0, 1'b1, 1'b0, 1'b0);
    step("same2", 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1);
    step("same3", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("same4", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("same.waddr", 32'(bus.rf_waddr), 32'd10);
    check_output("same.wdata", bus.rf_wdata, 32'hB);

    step("init.pulse", 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("init.enter", 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("init.busy", 32'(bus.init_busy), 32'd1);
    run_clear("reinit", 1'b0, 1'b1, 5'd7, 32'h77);
    step("init.data", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("init.idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    step("mr.req", 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    check_output("mr.we_before", 32'(bus.rf_we), 32'd1);
    check_output("mr.waddr_before", 32'(bus.rf_waddr), 32'd9);
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    check_output("mr.we_async", 32'(bus.rf_we), 32'd0);
    check_output("mr.waddr_async", 32'(bus.rf_waddr), 32'd0);
    check_output("mr.wdata_async", bus.rf_wdata, 32'd0);
    check_output("mr.busy_async", 32'(bus.init_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear("mr", 1'b0, 1'b0, 5'd0, 32'd0);
    step("mr.idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    check_output("sb.empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
